// File: rtl/rsc_frame_ctrl.sv
// rtl/rsc_frame_ctrl.sv - RSC encoder frame sequencer (IDLE/DATA/DRAIN/TAIL); TAIL phase enabled by RSC_CTRL_TAIL_EN
module rsc_frame_ctrl (
    input  logic        clk,
    input  logic        rst_N,
    input  logic [11:0] blk_len,
    input  logic        start,
    input  logic        s_valid,
    input  logic        s_data,
    output logic        s_ready,
    output logic        enc_in,
    output logic        enc_mode,
    output logic        enc_rst_N,
    input  logic        enc_x,
    input  logic        enc_z,
    output logic        m_valid,
    output logic        m_x,
    output logic        m_z,
    output logic        m_last,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_TAIL  = 2'd3
    } state_t;

    state_t      r_state;
    logic [11:0] r_k;
    logic [11:0] r_cnt;
    logic        r_v1;
    logic        r_l1;
    logic        w_xfer;
    logic        w_abort;
    logic        w_data_last;
    logic        w_in_vld;
    logic        w_in_last;
    logic        w_keep;

    assign w_xfer      = (r_state == ST_DATA) & s_valid;
    assign w_abort     = (r_state == ST_DATA) & ~s_valid;
    assign w_data_last = w_xfer & (r_cnt == (r_k - 12'd1));

    assign busy      = (r_state != ST_IDLE);
    assign s_ready   = (r_state == ST_DATA);
    assign enc_rst_N = (r_state != ST_IDLE);
    assign enc_in    = (r_state == ST_DATA) & s_data;

`ifdef RSC_CTRL_TAIL_EN
    logic [1:0] r_tcnt;

    // The encoder output lags its input by one cycle, so the last tail cycle is never captured.
    assign w_in_vld  = w_xfer | (r_state == ST_DRAIN) | ((r_state == ST_TAIL) & (r_tcnt != 2'd2));
    assign w_in_last = (r_state == ST_TAIL) & (r_tcnt == 2'd1);
    assign enc_mode  = (r_state == ST_TAIL);
`else
    assign w_in_vld  = w_xfer;
    assign w_in_last = w_data_last;
    assign enc_mode  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_N) begin
        if (!rst_N) begin
            r_state <= ST_IDLE;
            r_k     <= 12'd0;
            r_cnt   <= 12'd0;
            err     <= 1'b0;
`ifdef RSC_CTRL_TAIL_EN
            r_tcnt  <= 2'd0;
`endif
        end else begin
            err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (blk_len != 12'd0) begin
                            r_k     <= blk_len;
                            r_cnt   <= 12'd0;
                            r_state <= ST_DATA;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_abort) begin
                        r_state <= ST_IDLE;
                        err     <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 12'd1;
                        if (w_data_last) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
`ifdef RSC_CTRL_TAIL_EN
                    r_tcnt  <= 2'd0;
                    r_state <= ST_TAIL;
`else
                    r_state <= ST_IDLE;
`endif
                end
`ifdef RSC_CTRL_TAIL_EN
                ST_TAIL: begin
                    r_tcnt <= r_tcnt + 2'd1;
                    if (r_tcnt == 2'd2) begin
                        r_state <= ST_IDLE;
                    end
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // An abort also kills the symbol already in flight so nothing follows the err pulse.
    assign w_keep = r_v1 & ~w_abort;

    always_ff @(posedge clk or negedge rst_N) begin
        if (!rst_N) begin
            r_v1    <= 1'b0;
            r_l1    <= 1'b0;
            m_valid <= 1'b0;
            m_x     <= 1'b0;
            m_z     <= 1'b0;
            m_last  <= 1'b0;
        end else begin
            r_v1    <= w_in_vld;
            r_l1    <= w_in_last;
            m_valid <= w_keep;
            m_x     <= w_keep & enc_x;
            m_z     <= w_keep & enc_z;
            m_last  <= w_keep & r_l1;
        end
    end

endmodule

// File: tb/tb_rsc_frame_ctrl.sv
// tb/tb_rsc_frame_ctrl.sv - directed self-checking bench for rsc_frame_ctrl with a behavioural RSC encoder
module tb_rsc_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst_N;
    logic [11:0] blk_len;
    logic        start;
    logic        s_valid;
    logic        s_data;
    logic        s_ready;
    logic        enc_in;
    logic        enc_mode;
    logic        enc_rst_N;
    logic        enc_x;
    logic        enc_z;
    logic        m_valid;
    logic        m_x;
    logic        m_z;
    logic        m_last;
    logic        busy;
    logic        err;

`ifdef RSC_CTRL_TAIL_EN
    localparam int TAILN = 3;
`else
    localparam int TAILN = 0;
`endif
    localparam int LASTOFF = (TAILN == 3) ? 4 : 1;

    int n_checks = 0;
    int n_fail   = 0;

    logic ov [0:31];
    logic ox [0:31];
    logic oz [0:31];
    logic ol [0:31];
    logic om [0:31];
    logic ob [0:31];
    logic oe [0:31];
    logic orr[0:31];

    rsc_frame_ctrl dut (
        .clk       (clk),
        .rst_N     (rst_N),
        .blk_len   (blk_len),
        .start     (start),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .enc_in    (enc_in),
        .enc_mode  (enc_mode),
        .enc_rst_N (enc_rst_N),
        .enc_x     (enc_x),
        .enc_z     (enc_z),
        .m_valid   (m_valid),
        .m_x       (m_x),
        .m_z       (m_z),
        .m_last    (m_last),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Registered RSC encoder, g0 = 1+D^2+D^3 feedback, g1 = 1+D+D^3; mode=1 feeds back for termination.
    logic [2:0] es;
    always @(posedge clk) begin : enc_model
        logic fb;
        logic a;
        logic u;
        if (!enc_rst_N) begin
            es    <= 3'b000;
            enc_x <= 1'b0;
            enc_z <= 1'b0;
        end else begin
            fb = es[1] ^ es[2];
            u  = enc_mode ? fb : enc_in;
            a  = enc_mode ? 1'b0 : (enc_in ^ fb);
            enc_x <= u;
            enc_z <= a ^ es[0] ^ es[2];
            es    <= {es[1], es[0], a};
        end
    end

    task automatic run_frame(input int k, input logic [15:0] bits, input int gap, input int ncyc);
        @(posedge clk); #1;
        start   = 1'b1;
        blk_len = k[11:0];
        s_valid = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk); #1;
            start   = 1'b0;
            s_valid = (c < k) && (c != gap);
            s_data  = (c < k) ? bits[c] : 1'b0;
            @(negedge clk);
            ov[c] = m_valid; ox[c] = m_x; oz[c] = m_z; ol[c] = m_last;
            om[c] = enc_mode; ob[c] = busy; oe[c] = err; orr[c] = s_ready;
        end
    endtask

    task automatic test_reset;
        rst_N = 1'b0; start = 1'b1; blk_len = 12'd5; s_valid = 1'b1; s_data = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({s_ready, enc_rst_N, enc_mode, enc_in} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_enc_ctl got=%b want=0000", {s_ready, enc_rst_N, enc_mode, enc_in});
        end
        n_checks++;
        if ({m_valid, m_x, m_z, m_last} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_m got=%b want=0000", {m_valid, m_x, m_z, m_last});
        end
        n_checks++;
        if ({busy, err} !== 2'b00) begin
            n_fail++; $display("FAIL reset_busy_err got=%b want=00", {busy, err});
        end
        start = 1'b0; s_valid = 1'b0; s_data = 1'b0;
        #2 rst_N = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_nominal;
        logic [7:0] ex;
        logic [7:0] ez;
        int k;
        int last;
        k = 4;
        last = k + LASTOFF;
        ex = (TAILN == 3) ? 8'b0000_1101 : 8'b0000_1101;
        ez = (TAILN == 3) ? 8'b0000_1011 : 8'b0000_1011;
        run_frame(k, 16'b1101, -1, last + 3);
        for (int c = 0; c < last + 3; c++) begin
            n_checks++;
            if (ov[c] !== (c >= 2 && c <= last)) begin
                n_fail++; $display("FAIL nom_valid c=%0d got=%b want=%b", c, ov[c], (c >= 2 && c <= last));
            end
            if (c >= 2 && c <= last) begin
                n_checks++;
                if (ox[c] !== ex[c-2] || oz[c] !== ez[c-2]) begin
                    n_fail++; $display("FAIL nom_xz c=%0d got=%b%b want=%b%b", c, ox[c], oz[c], ex[c-2], ez[c-2]);
                end
            end
            n_checks++;
            if (ol[c] !== (c == last)) begin
                n_fail++; $display("FAIL nom_last c=%0d got=%b want=%b", c, ol[c], (c == last));
            end
            n_checks++;
            if (om[c] !== (TAILN == 3 && c >= k + 1 && c <= k + 3)) begin
                n_fail++; $display("FAIL nom_mode c=%0d got=%b", c, om[c]);
            end
            n_checks++;
            if (ob[c] !== (c <= k + TAILN) || orr[c] !== (c < k) || oe[c] !== 1'b0) begin
                n_fail++; $display("FAIL nom_busy_ready_err c=%0d got=%b%b%b", c, ob[c], orr[c], oe[c]);
            end
        end
    endtask

    task automatic test_abort;
        run_frame(4, 16'b1111, 2, 8);
        for (int c = 0; c < 8; c++) begin
            n_checks++;
            if (oe[c] !== (c == 3)) begin
                n_fail++; $display("FAIL abort_err c=%0d got=%b want=%b", c, oe[c], (c == 3));
            end
            n_checks++;
            if (ob[c] !== (c < 3)) begin
                n_fail++; $display("FAIL abort_busy c=%0d got=%b want=%b", c, ob[c], (c < 3));
            end
            n_checks++;
            if (ov[c] !== (c == 2) || ol[c] !== 1'b0) begin
                n_fail++; $display("FAIL abort_m c=%0d got v=%b l=%b want v=%b l=0", c, ov[c], ol[c], (c == 2));
            end
        end
        n_checks++;
        if (ox[2] !== 1'b1 || oz[2] !== 1'b1) begin
            n_fail++; $display("FAIL abort_first_sym got=%b%b want=11", ox[2], oz[2]);
        end
    endtask

    task automatic test_zero_len;
        run_frame(0, 16'b0, -1, 4);
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (oe[c] !== (c == 0)) begin
                n_fail++; $display("FAIL zlen_err c=%0d got=%b want=%b", c, oe[c], (c == 0));
            end
            n_checks++;
            if (ob[c] !== 1'b0 || ov[c] !== 1'b0) begin
                n_fail++; $display("FAIL zlen_busy_valid c=%0d got=%b%b want=00", c, ob[c], ov[c]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int b1;
        int f2;
        int last1;
        int last2;
        int nc;
        int n1;
        int n2;
        logic [7:0] x1;
        logic [7:0] z1;
        logic [7:0] x2;
        logic [7:0] z2;
        b1 = 1 + TAILN;
        f2 = b1 + 2;
        last1 = 1 + LASTOFF;
        last2 = f2 + 2 + LASTOFF;
        n1 = 1 + TAILN;
        n2 = 2 + TAILN;
        nc = last2 + 3;
        x1 = (TAILN == 3) ? 8'b0000_1101 : 8'b0000_0001;
        z1 = (TAILN == 3) ? 8'b0000_1011 : 8'b0000_0001;
        x2 = (TAILN == 3) ? 8'b0001_1001 : 8'b0000_0001;
        z2 = (TAILN == 3) ? 8'b0000_0111 : 8'b0000_0011;
        @(posedge clk); #1;
        start = 1'b1; blk_len = 12'd1; s_valid = 1'b0;
        for (int c = 0; c < nc; c++) begin
            @(posedge clk); #1;
            blk_len = 12'd2;
            start   = (c < f2);
            s_valid = (c == 0) || (c == f2) || (c == f2 + 1);
            s_data  = (c == 0) || (c == f2);
            @(negedge clk);
            ov[c] = m_valid; ox[c] = m_x; oz[c] = m_z; ol[c] = m_last;
            ob[c] = busy; orr[c] = s_ready;
        end
        n_checks++;
        if (ob[f2-1] !== 1'b0 || orr[f2] !== 1'b1 || ob[f2-2] !== 1'b1) begin
            n_fail++; $display("FAIL b2b_restart got busy=%b%b ready=%b want 10 1", ob[f2-2], ob[f2-1], orr[f2]);
        end
        for (int c = 0; c < nc; c++) begin
            n_checks++;
            if (ol[c] !== (c == last1 || c == last2)) begin
                n_fail++; $display("FAIL b2b_last c=%0d got=%b", c, ol[c]);
            end
            n_checks++;
            if (ov[c] !== ((c >= 2 && c < 2 + n1) || (c >= f2 + 2 && c < f2 + 2 + n2))) begin
                n_fail++; $display("FAIL b2b_valid c=%0d got=%b", c, ov[c]);
            end
        end
        for (int i = 0; i < n1; i++) begin
            n_checks++;
            if (ox[2+i] !== x1[i] || oz[2+i] !== z1[i]) begin
                n_fail++; $display("FAIL b2b_f1_sym i=%0d got=%b%b want=%b%b", i, ox[2+i], oz[2+i], x1[i], z1[i]);
            end
        end
        for (int i = 0; i < n2; i++) begin
            n_checks++;
            if (ox[f2+2+i] !== x2[i] || oz[f2+2+i] !== z2[i]) begin
                n_fail++; $display("FAIL b2b_f2_sym i=%0d got=%b%b want=%b%b", i, ox[f2+2+i], oz[f2+2+i], x2[i], z2[i]);
            end
        end
    endtask

    task automatic test_reset_mid;
        int rc;
        int n2;
        logic [7:0] x2;
        logic [7:0] z2;
        rc = (TAILN == 3) ? 6 : 2;
        n2 = 2 + TAILN;
        x2 = (TAILN == 3) ? 8'b0001_1001 : 8'b0000_0001;
        z2 = (TAILN == 3) ? 8'b0000_0111 : 8'b0000_0011;
        run_frame(4, 16'b0111, -1, rc);
        @(posedge clk); #1;
        rst_N = 1'b0;
        #1;
        n_checks++;
        if ({s_ready, enc_rst_N, enc_mode, enc_in, busy, err} !== 6'b0) begin
            n_fail++; $display("FAIL rstmid_ctl got=%b want=000000", {s_ready, enc_rst_N, enc_mode, enc_in, busy, err});
        end
        n_checks++;
        if ({m_valid, m_x, m_z, m_last} !== 4'b0) begin
            n_fail++; $display("FAIL rstmid_m got=%b want=0000", {m_valid, m_x, m_z, m_last});
        end
        s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_N = 1'b1;
        run_frame(2, 16'b01, -1, n2 + 4);
        for (int i = 0; i < n2; i++) begin
            n_checks++;
            if (ov[2+i] !== 1'b1 || ox[2+i] !== x2[i] || oz[2+i] !== z2[i]) begin
                n_fail++; $display("FAIL rstmid_sym i=%0d got v=%b xz=%b%b want=1 %b%b", i, ov[2+i], ox[2+i], oz[2+i], x2[i], z2[i]);
            end
        end
        n_checks++;
        if (ol[1+n2] !== 1'b1 || ol[n2] !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_last got=%b%b want=01", ol[n2], ol[1+n2]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_nominal;
        test_abort;
        test_zero_len;
        test_back_to_back;
        test_reset_mid;
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rsc_frame_ctrl.md
RSC_FRAME_CTRL -- requirements
Module: rsc_frame_ctrl

Interface
REQ-001 SHALL have ports clk (in, 1, sole clock, rising edge) and rst_N (in, 1, asynchronous, active-low reset).
REQ-002 SHALL have port blk_len (in, 12): frame length K in bits, 1..4095, sampled on start acceptance.
REQ-003 SHALL have port start (in, 1): frame request, accepted only in IDLE.
REQ-004 SHALL have ports s_valid (in, 1), s_data (in, 1), s_ready (out, 1): input bit stream, transfer on s_valid&s_ready.
REQ-005 SHALL have ports enc_in (out, 1), enc_mode (out, 1), enc_rst_N (out, 1): drive the encoder's in, mode and rst_N.
REQ-006 SHALL have ports enc_x (in, 1), enc_z (in, 1): encoder x_out and z_out.
REQ-007 SHALL have ports m_valid, m_x, m_z, m_last (out, 1 each): encoded output stream with no backpressure; m_last marks the final symbol.
REQ-008 SHALL have ports busy (out, 1) and err (out, 1): busy means state is not IDLE; err is a one-cycle fault pulse.

Function
REQ-009 SHALL implement the states IDLE, DATA, DRAIN and TAIL; busy=0 only in IDLE.
REQ-010 IDLE: enc_rst_N=0, enc_mode=0, s_ready=0; start with blk_len!=0 -> latch K, go to DATA; start with blk_len=0 -> err pulse next cycle, stay IDLE.
REQ-011 DATA (frame cycles 0..K-1): s_ready=1, enc_rst_N=1, enc_mode=0, enc_in=s_data (combinational); after K transfers go to DRAIN.
REQ-012 DRAIN (cycle K, one cycle): s_ready=0, enc_mode=0, enc_in=0, enc_rst_N=1; then go to TAIL (or IDLE, see REQ-020).
REQ-013 TAIL (cycles K+1..K+3): enc_mode=1, enc_in=0, enc_rst_N=1, s_ready=0; after 3 cycles go to IDLE.
REQ-014 enc_x/enc_z in cycles 1..K+3 SHALL be registered to m_x/m_z with m_valid=1 in cycles 2..K+4; otherwise m_valid=0.
REQ-015 m_last SHALL be 1 only alongside the final m_valid of a frame.
REQ-016 An s_valid=0 seen in any DATA cycle j SHALL abort the frame: err=1 in cycle j+1; state IDLE in cycle j+1; no m_valid from cycle j+1 on; no m_last.
REQ-017 start SHALL be ignored while busy=1; start in the first IDLE cycle after a frame is accepted, so back-to-back frames are legal.
REQ-018 enc_mode and enc_rst_N SHALL be decoded from the registered state only.

Reset
REQ-019 While rst_N=0, regardless of clk: state=IDLE, s_ready=0, enc_rst_N=0, enc_mode=0, enc_in=0, m_valid=m_x=m_z=m_last=0, busy=0, err=0, latched K=0; reset mid-frame discards the frame.

Configuration
REQ-020 Macro RSC_CTRL_TAIL_EN: defined -> TAIL state present, m_last at cycle K+4; undefined -> DRAIN goes directly to IDLE, enc_mode is constant 0, m_valid in cycles 2..K+1, m_last at cycle K+1.

Verification
REQ-021 TAIL_EN, K=4, data 1,0,1,1 without gaps:
- m_x=1,0,1,1,0,0,0 and m_z=1,1,0,1,0,0,0 in cycles 2..8.
- m_last in cycle 8.
- enc_mode=1 in cycles 5..7.
REQ-022 Without TAIL_EN, same stimulus:
- m_x=1,0,1,1 and m_z=1,1,0,1 in cycles 2..5.
- m_last in cycle 5.
- enc_mode never 1.
REQ-023 K=4, s_valid=0 in DATA cycle 2:
- err=1 in cycle 3 only.
- busy=0 from cycle 3.
- m_valid=0 from cycle 3; no m_last.
REQ-024 start with blk_len=0: err=1 for one cycle, busy stays 0, no m_valid.
REQ-025 Back-to-back frames: start held high, K=1 then K=2 -> two m_last pulses, second frame's DATA begins the cycle after busy falls, and outputs match independent encodings.
REQ-026 rst_N=0 mid-TAIL: all outputs at reset values immediately; a following frame encodes correctly from a zero encoder state.
